ex_iter_alu: RTL

- Parametrised execute-stage ALU for the RISC-V pipeline, sitting between ID/EX and EX/MEM.
- Adds arithmetic ops: ADD, SUB, SLT, SLTU.
- Uses a valid/ready handshake on both sides.
- Replaces the single-cycle barrel shifter with an iterative shifter of configurable step size.
- Results are registered and held until the downstream stage accepts them.

---
 rtl/ex_iter_alu.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ex_iter_alu.sv
// Execute-stage ALU with valid/ready handshakes and an iterative shifter
// that moves SHIFT_STEP bit positions per cycle; results are held until accepted.
module ex_iter_alu #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1,
   parameter int AW         = 5,
   parameter int OPW        = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [OPW-1:0]  aluop_i,
   input  logic [XLEN-1:0] r1_data_i,
   input  logic [XLEN-1:0] r2_data_i,
   input  logic            w_enable_i,
   input  logic [AW-1:0]   w_addr_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic            w_enable_o,
   output logic [AW-1:0]   w_addr_o,
   output logic [XLEN-1:0] w_data_o
);

   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW-1:0] STEP_L = SHW'(SHIFT_STEP);

   localparam logic [OPW-1:0] OP_OR   = OPW'(0);
   localparam logic [OPW-1:0] OP_XOR  = OPW'(1);
   localparam logic [OPW-1:0] OP_AND  = OPW'(2);
   localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
   localparam logic [OPW-1:0] OP_SLT  = OPW'(5);
   localparam logic [OPW-1:0] OP_SLTU = OPW'(6);
   localparam logic [OPW-1:0] OP_SLL  = OPW'(7);
   localparam logic [OPW-1:0] OP_SRL  = OPW'(8);
   localparam logic [OPW-1:0] OP_SRA  = OPW'(9);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] work_q, work_d;
   logic [SHW-1:0]  rem_q, rem_d;
   logic [OPW-1:0]  op_q, op_d;
   logic            sign_q, sign_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            wen_req_q, wen_req_d;
   logic            w_enable_d;
   logic [AW-1:0]   w_addr_d;
   logic [XLEN-1:0] w_data_d;

   logic            accept;
   logic            is_shift;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_res;
   logic [SHW-1:0]  step;
   logic [XLEN-1:0] shifted;
   logic signed [XLEN:0] sra_ext;

   assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
   assign out_valid_o = (state_q == DONE);
   assign accept      = in_valid_i && in_ready_o;
   assign shamt       = r2_data_i[SHW-1:0];
   assign is_shift    = (aluop_i == OP_SLL) || (aluop_i == OP_SRL) || (aluop_i == OP_SRA);

   // Single-cycle result; a shift only reaches here with a zero amount, so it passes A through.
   always_comb begin
      alu_res = '0;
      case (aluop_i)
         OP_OR:   alu_res = r1_data_i | r2_data_i;
         OP_XOR:  alu_res = r1_data_i ^ r2_data_i;
         OP_AND:  alu_res = r1_data_i & r2_data_i;
         OP_ADD:  alu_res = r1_data_i + r2_data_i;
         OP_SUB:  alu_res = r1_data_i - r2_data_i;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(r1_data_i) < $signed(r2_data_i))};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (r1_data_i < r2_data_i)};
         OP_SLL,
         OP_SRL,
         OP_SRA:  alu_res = r1_data_i;
         default: alu_res = '0;
      endcase
   end

   // One iteration of the shifter: at most SHIFT_STEP positions, never past the remaining amount.
   always_comb begin
      step    = (rem_q < STEP_L) ? rem_q : STEP_L;
      sra_ext = $signed({sign_q, work_q}) >>> step;
      shifted = '0;
      case (op_q)
         OP_SLL:  shifted = work_q << step;
         OP_SRL:  shifted = work_q >> step;
         default: shifted = sra_ext[XLEN-1:0];
      endcase
   end

   // Next-state and next-output logic; accept overrides the DONE drain, flush overrides everything.
   always_comb begin
      state_d    = state_q;
      work_d     = work_q;
      rem_d      = rem_q;
      op_d       = op_q;
      sign_d     = sign_q;
      addr_d     = addr_q;
      wen_req_d  = wen_req_q;
      w_enable_d = w_enable_o;
      w_addr_d   = w_addr_o;
      w_data_d   = w_data_o;

      case (state_q)
         SHIFT: begin
            work_d = shifted;
            rem_d  = rem_q - step;
            if (rem_q == step) begin
               state_d    = DONE;
               w_enable_d = wen_req_q && (addr_q != '0);
               w_addr_d   = addr_q;
               w_data_d   = (addr_q != '0) ? shifted : '0;
            end
         end
         DONE: begin
            if (out_ready_i) begin
               state_d    = IDLE;
               w_enable_d = 1'b0;
            end
         end
         default: ;
      endcase

      if (accept) begin
         if (is_shift && (shamt != '0)) begin
            state_d    = SHIFT;
            work_d     = r1_data_i;
            rem_d      = shamt;
            op_d       = aluop_i;
            sign_d     = r1_data_i[XLEN-1];
            addr_d     = w_addr_i;
            wen_req_d  = w_enable_i;
            w_enable_d = 1'b0;
         end else begin
            state_d    = DONE;
            w_enable_d = w_enable_i && (w_addr_i != '0);
            w_addr_d   = w_addr_i;
            w_data_d   = (w_addr_i != '0) ? alu_res : '0;
         end
      end

      if (flush_i) begin
         state_d    = IDLE;
         w_enable_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         work_q     <= '0;
         rem_q      <= '0;
         op_q       <= '0;
         sign_q     <= 1'b0;
         addr_q     <= '0;
         wen_req_q  <= 1'b0;
         w_enable_o <= 1'b0;
         w_addr_o   <= '0;
         w_data_o   <= '0;
      end else begin
         state_q    <= state_d;
         work_q     <= work_d;
         rem_q      <= rem_d;
         op_q       <= op_d;
         sign_q     <= sign_d;
         addr_q     <= addr_d;
         wen_req_q  <= wen_req_d;
         w_enable_o <= w_enable_d;
         w_addr_o   <= w_addr_d;
         w_data_o   <= w_data_d;
      end
   end

endmodule
